// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one instruction-bus request at a time,
// passes the returning word straight through to decode, buffers it when
// decode stalls, discards responses made stale by redirects or flushes, and
// turns misaligned fetch targets into an exception slot.

package fetch_unit_pkg;

   typedef enum logic [1:0] {
      CSR_NONE      = 2'd0,
      CSR_EXCEPTION = 2'd1
   } csr_type_t;

   typedef struct packed {
      csr_type_t  ctype;
      logic [3:0] code;
   } csr_ctl_t;

   typedef struct packed {
      logic [31:0] raw_instr;
      logic [63:0] pc;
      logic        valid;
      csr_ctl_t    csr_ctl;
      logic [1:0]  int_type;
   } fetch_data_t;

endpackage

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_addr_ok,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        stallF,
   input  logic        flushF,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   input  logic        trap_valid,
   input  logic [63:0] trap_pc,
   output fetch_data_t dataF
);

   typedef enum logic [1:0] {
      FETCH,
      HOLD,
      DRAIN,
      EXC
   } stateT;

   stateT       state, stateNext;
   logic [63:0] pc, pcNext;
   logic [31:0] bufInstr, bufInstrNext;
   logic [63:0] savedTarget, savedTargetNext;

   logic        redirectAny;
   logic [63:0] redirectTarget;
   logic [63:0] drainTarget;
   logic [63:0] pcPlus4;
   logic        unusedAddrOk;

   // Any fetch target that is not word aligned lands in the exception slot
   // instead of going out on the bus.
   function automatic stateT stateFor(input logic [1:0] addrLow);
      return (addrLow != 2'b00) ? EXC : FETCH;
   endfunction

   // Address acceptance carries no information for a single-outstanding fetcher.
   assign unusedAddrOk = iresp_addr_ok;

   // Traps and returns beat ordinary branch redirects; while draining, the
   // newest redirect replaces whatever target was saved earlier.
   assign redirectAny    = trap_valid | redirect_valid;
   assign redirectTarget = trap_valid ? trap_pc : redirect_pc;
   assign drainTarget    = redirectAny ? redirectTarget : savedTarget;
   assign pcPlus4        = pc + 64'd4;

   // State, PC, hold buffer and drain target registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         bufInstr    <= NOP_INSTR;
         savedTarget <= RESET_PC;
      end else begin
         state       <= stateNext;
         pc          <= pcNext;
         bufInstr    <= bufInstrNext;
         savedTarget <= savedTargetNext;
      end
   end

   // Next-state logic plus bus request and decode-facing outputs. The request
   // address is always the PC register, so it cannot move while outstanding.
   always_comb begin
      stateNext       = state;
      pcNext          = pc;
      bufInstrNext    = bufInstr;
      savedTargetNext = savedTarget;
      ireq_valid      = 1'b0;
      ireq_addr       = pc;
      dataF           = '0;
      dataF.raw_instr = NOP_INSTR;
      dataF.pc        = pc;
      dataF.csr_ctl.ctype = CSR_NONE;

      case (state)
         FETCH: begin
            ireq_valid = 1'b1;
            if (iresp_data_ok) begin
               dataF.raw_instr = iresp_data;
               dataF.valid     = ~redirectAny;
               if (redirectAny) begin
                  pcNext    = redirectTarget;
                  stateNext = stateFor(redirectTarget[1:0]);
               end else if (flushF) begin
                  stateNext = FETCH;
               end else if (stallF) begin
                  bufInstrNext = iresp_data;
                  stateNext    = HOLD;
               end else begin
                  pcNext    = pcPlus4;
                  stateNext = stateFor(pcPlus4[1:0]);
               end
            end else if (redirectAny || flushF) begin
               savedTargetNext = redirectAny ? redirectTarget : pc;
               stateNext       = DRAIN;
            end
         end

         HOLD: begin
            dataF.valid     = 1'b1;
            dataF.raw_instr = bufInstr;
            if (redirectAny) begin
               pcNext    = redirectTarget;
               stateNext = stateFor(redirectTarget[1:0]);
            end else if (flushF) begin
               stateNext = stateFor(pc[1:0]);
            end else if (!stallF) begin
               pcNext    = pcPlus4;
               stateNext = stateFor(pcPlus4[1:0]);
            end
         end

         DRAIN: begin
            ireq_valid = 1'b1;
            if (iresp_data_ok) begin
               pcNext    = drainTarget;
               stateNext = stateFor(drainTarget[1:0]);
            end else begin
               savedTargetNext = drainTarget;
            end
         end

         EXC: begin
            dataF.valid         = 1'b1;
            dataF.csr_ctl.ctype = CSR_EXCEPTION;
            dataF.csr_ctl.code  = 4'h0;
            if (redirectAny) begin
               pcNext    = redirectTarget;
               stateNext = stateFor(redirectTarget[1:0]);
            end else if (flushF) begin
               stateNext = stateFor(pc[1:0]);
            end
         end

         default: begin
            stateNext = FETCH;
         end
      endcase

      if (reset) begin
         ireq_valid  = 1'b0;
         dataF.valid = 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cycle table for the directed corner
// cases, a mid-request reset sequence, and a scoreboarded random stream
// against a simple memory responder.

module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [63:0] R = 64'h0000_0000_8000_0000;
   localparam logic [31:0] N = 32'h0000_0013;
   localparam logic [63:0] W = 64'hFFFF_FFFF_FFFF_FFFC;

   logic        clk;
   logic        reset;
   logic        ireq_valid;
   logic [63:0] ireq_addr;
   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        stallF;
   logic        flushF;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        trap_valid;
   logic [63:0] trap_pc;
   fetch_data_t dataF;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        redir;
      logic [63:0] redirPc;
      logic        trap;
      logic [63:0] trapPc;
      logic        dOk;
      logic [31:0] data;
      logic        eReqV;
      logic [63:0] eAddr;
      logic        eV;
      logic [31:0] eRaw;
      logic [63:0] ePc;
      logic        eExc;
   } vecT;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } sbEntry;

   vecT    tbl[$];
   sbEntry sbQueue[$];

   fetch_unit #(
      .RESET_PC (R),
      .NOP_INSTR(N)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ireq_valid    (ireq_valid),
      .ireq_addr     (ireq_addr),
      .iresp_addr_ok (iresp_addr_ok),
      .iresp_data_ok (iresp_data_ok),
      .iresp_data    (iresp_data),
      .stallF        (stallF),
      .flushF        (flushF),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .trap_valid    (trap_valid),
      .trap_pc       (trap_pc),
      .dataF         (dataF)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memWord(input logic [63:0] addr);
      return addr[31:0] ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input vecT v);
      stallF         = v.stall;
      flushF         = v.flush;
      redirect_valid = v.redir;
      redirect_pc    = v.redirPc;
      trap_valid     = v.trap;
      trap_pc        = v.trapPc;
      iresp_data_ok  = v.dOk;
      iresp_addr_ok  = v.eReqV;
      iresp_data     = v.data;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Directed table, random stream with scoreboard, then the summary.
   initial begin
      vecT idle;
      logic [63:0] modelPc;
      int          waitCnt;

      idle = '{0, 0, 0, 64'd0, 0, 64'd0, 0, 32'd0, 0, 64'd0, 0, 32'd0, 64'd0, 0};
      applyStimulus(idle);
      reset = 1'b1;
      nextCycle();
      nextCycle();
      @(negedge clk);
      checkOutput("reset ireq_valid", {63'd0, ireq_valid}, 64'd0);
      checkOutput("reset dataF.valid", {63'd0, dataF.valid}, 64'd0);
      checkOutput("reset int_type", {62'd0, dataF.int_type}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R,        0,32'd0,R,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R,        0,32'd0,R,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,1,32'h0050_0093,     1,R,        1,32'h0050_0093,R,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R+4,      0,32'd0,0,0});
      tbl.push_back('{1,0,0,64'd0,0,64'd0,1,32'h1111_1111,     1,R+4,      1,32'h1111_1111,R+4,0});
      tbl.push_back('{1,0,0,64'd0,0,64'd0,0,32'd0,             0,0,        1,32'h1111_1111,R+4,0});
      tbl.push_back('{1,0,0,64'd0,0,64'd0,0,32'd0,             0,0,        1,32'h1111_1111,R+4,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             0,0,        1,32'h1111_1111,R+4,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R+8,      0,32'd0,0,0});
      tbl.push_back('{0,0,1,R+'h100,0,64'd0,0,32'd0,           1,R+8,      0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R+8,      0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,1,32'hDEAD_BEEF,     1,R+8,      0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R+'h100,  0,32'd0,0,0});
      tbl.push_back('{0,0,1,R+'h100,1,R+'h200,0,32'd0,         1,R+'h100,  0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,1,32'hBAD0_BAD0,     1,R+'h100,  0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R+'h200,  0,32'd0,0,0});
      tbl.push_back('{0,0,1,R+'h300,0,64'd0,0,32'd0,           1,R+'h200,  0,32'd0,0,0});
      tbl.push_back('{0,0,1,R+'h400,0,64'd0,0,32'd0,           1,R+'h200,  0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,1,32'h0BAD_0BAD,     1,R+'h200,  0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R+'h400,  0,32'd0,0,0});
      tbl.push_back('{0,0,1,R+'h500,0,64'd0,1,32'h2222_2222,   1,R+'h400,  0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R+'h500,  0,32'd0,0,0});
      tbl.push_back('{1,0,0,64'd0,0,64'd0,1,32'h3333_3333,     1,R+'h500,  1,32'h3333_3333,R+'h500,0});
      tbl.push_back('{1,0,1,R+'h600,0,64'd0,0,32'd0,           0,0,        1,32'h3333_3333,R+'h500,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R+'h600,  0,32'd0,0,0});
      tbl.push_back('{0,0,1,R+'h102,0,64'd0,0,32'd0,           1,R+'h600,  0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,1,32'h4444_4444,     1,R+'h600,  0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             0,0,        1,N,R+'h102,1});
      tbl.push_back('{1,0,0,64'd0,0,64'd0,0,32'd0,             0,0,        1,N,R+'h102,1});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             0,0,        1,N,R+'h102,1});
      tbl.push_back('{0,0,1,R+'h700,0,64'd0,0,32'd0,           0,0,        1,N,R+'h102,1});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R+'h700,  0,32'd0,0,0});
      tbl.push_back('{0,1,0,64'd0,0,64'd0,0,32'd0,             1,R+'h700,  0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,1,32'h5555_5555,     1,R+'h700,  0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R+'h700,  0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,1,32'h6666_6666,     1,R+'h700,  1,32'h6666_6666,R+'h700,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,R+'h704,  0,32'd0,0,0});
      tbl.push_back('{0,0,1,W,0,64'd0,0,32'd0,                 1,R+'h704,  0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,1,32'h0000_0000,     1,R+'h704,  0,32'd0,0,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,1,32'h7777_7777,     1,W,        1,32'h7777_7777,W,0});
      tbl.push_back('{0,0,0,64'd0,0,64'd0,0,32'd0,             1,64'd0,    0,32'd0,0,0});

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         @(negedge clk);
         checkOutput($sformatf("row%0d ireq_valid", i), {63'd0, ireq_valid}, {63'd0, tbl[i].eReqV});
         if (tbl[i].eReqV)
            checkOutput($sformatf("row%0d ireq_addr", i), ireq_addr, tbl[i].eAddr);
         checkOutput($sformatf("row%0d dataF.valid", i), {63'd0, dataF.valid}, {63'd0, tbl[i].eV});
         if (tbl[i].eV) begin
            checkOutput($sformatf("row%0d raw_instr", i), {32'd0, dataF.raw_instr}, {32'd0, tbl[i].eRaw});
            checkOutput($sformatf("row%0d pc", i), dataF.pc, tbl[i].ePc);
            checkOutput($sformatf("row%0d ctype", i), {62'd0, dataF.csr_ctl.ctype},
                        tbl[i].eExc ? {62'd0, CSR_EXCEPTION} : {62'd0, CSR_NONE});
            if (tbl[i].eExc)
               checkOutput($sformatf("row%0d code", i), {60'd0, dataF.csr_ctl.code}, 64'd0);
         end else if (tbl[i].eReqV && !tbl[i].dOk) begin
            checkOutput($sformatf("row%0d bubble raw", i), {32'd0, dataF.raw_instr}, {32'd0, N});
         end
         checkOutput($sformatf("row%0d int_type", i), {62'd0, dataF.int_type}, 64'd0);
         nextCycle();
      end

      // Reset with a response arriving in the same cycle: nothing is presented,
      // then fetching restarts at the reset PC.
      applyStimulus(idle);
      iresp_data_ok = 1'b1;
      iresp_data    = 32'h9999_9999;
      reset         = 1'b1;
      @(negedge clk);
      checkOutput("midreset ireq_valid", {63'd0, ireq_valid}, 64'd0);
      checkOutput("midreset dataF.valid", {63'd0, dataF.valid}, 64'd0);
      nextCycle();
      reset         = 1'b0;
      iresp_data_ok = 1'b0;
      @(negedge clk);
      checkOutput("postreset ireq_valid", {63'd0, ireq_valid}, 64'd1);
      checkOutput("postreset ireq_addr", ireq_addr, R);
      checkOutput("postreset dataF.valid", {63'd0, dataF.valid}, 64'd0);
      nextCycle();

      // Random stream: memory responder with 0..2 cycle latency and random
      // stalls; the model expects strictly sequential PCs from the reset PC.
      modelPc = R;
      waitCnt = $urandom_range(0, 2);
      for (int cyc = 0; cyc < 300; cyc++) begin
         applyStimulus(idle);
         stallF = (cyc < 280) && ($urandom_range(0, 3) == 0);
         if (ireq_valid) begin
            if (waitCnt == 0) begin
               iresp_data_ok = 1'b1;
               iresp_addr_ok = 1'b1;
               iresp_data    = memWord(ireq_addr);
               sbQueue.push_back('{modelPc, memWord(modelPc)});
               modelPc = modelPc + 64'd4;
               waitCnt = $urandom_range(0, 2);
            end else begin
               waitCnt--;
            end
         end
         @(negedge clk);
         if (dataF.valid && !stallF) begin
            if (sbQueue.size() == 0) begin
               checkOutput("stream unexpected accept", dataF.pc, 64'd0 - 64'd1);
            end else begin
               sbEntry e;
               e = sbQueue.pop_front();
               checkOutput("stream pc", dataF.pc, e.pc);
               checkOutput("stream raw_instr", {32'd0, dataF.raw_instr}, {32'd0, e.instr});
            end
         end
         nextCycle();
      end
      checkOutput("stream leftover", 64'(sbQueue.size()), 64'd0);
      checkOutput("stream progressed", {63'd0, modelPc > R + 64'd40}, 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
